alu_share_ctrl: RTL and testbench

- Controller that shares the single 8-bit registered ALU (opcode/rs/rt in; result/set out one clock later) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready request and response handshakes, operand latching, ALU sequencing and result capture.
- Sits between pipeline/micro-sequencer clients and the ALU; it is the ALU's only driver.

---
 rtl/alu_ctrl_pkg.sv | 26 ++
 rtl/alu_share_ctrl_rr_pick.sv | 32 +++
 rtl/alu_share_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU-sharing controller: ALU opcodes, FSM states and
// the rule for which opcodes produce a meaningful set flag.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_ABS = 3'b110;
  localparam logic [2:0] OP_SEQ = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  // Only compare-type operations drive a set flag that clients may rely on.
  function automatic logic op_sets_flag(input logic [2:0] op);
    return (op == OP_SLT) || (op == OP_SEQ);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_pick.sv
// rr_pick: combinational circular priority picker. Searches req upward from start,
// wrapping, and returns the first set bit as one-hot grant plus its index.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, start} + (IDX_W + 1)'(i);
      if (k >= (IDX_W + 1)'(N)) k = k - (IDX_W + 1)'(N);
      if (!any && req[k[IDX_W-1:0]]) begin
        any                = 1'b1;
        grant[k[IDX_W-1:0]] = 1'b1;
        idx                = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one registered ALU between NUM_REQ requesters (IDLE/ISSUE/WAIT/RESPOND).
// Define ALU_SHARE_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int OP_W    = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ*OP_W-1:0]     req_opcode_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_rs_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_rt_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  input  logic [NUM_REQ-1:0]          rsp_ready_i,
  output logic [DATA_W-1:0]           rsp_result_o,
  output logic                        rsp_set_o,
  output logic [OP_W-1:0]             alu_opcode_o,
  output logic [DATA_W-1:0]           alu_rs_o,
  output logic [DATA_W-1:0]           alu_rt_o,
  input  logic [DATA_W-1:0]           alu_result_i,
  input  logic                        alu_set_i,
  output logic                        busy_o,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    grant_q, start;
  logic [OP_W-1:0]     op_q, sel_op;
  logic [DATA_W-1:0]   rs_q, rt_q, res_q, sel_rs, sel_rt;
  logic                set_q;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                owner_ready;

  assign owner_ready = rsp_ready_i[grant_q];

`ifdef ALU_SHARE_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDX_W-1:0] rr_ptr;

  // The search for the next round begins just past the requester served last.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
    end else if (state == ST_RESPOND && owner_ready) begin
      rr_ptr <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end
  end

  assign start = rr_ptr;
`endif

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid_i),
    .start (start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_op = '0;
    sel_rs = '0;
    sel_rt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_grant[k]) begin
        sel_op = req_opcode_i[k*OP_W +: OP_W];
        sel_rs = req_rs_i[k*DATA_W +: DATA_W];
        sel_rt = req_rt_i[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    case (state)
      ST_IDLE: begin
        req_ready_o = pick_grant;
        if (pick_any) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  state_nxt = ST_RESPOND;
      ST_RESPOND: begin
        rsp_valid_o[grant_q] = 1'b1;
        if (owner_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      op_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      res_q   <= '0;
      set_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && pick_any) begin
        grant_q <= pick_idx;
        op_q    <= sel_op;
        rs_q    <= sel_rs;
        rt_q    <= sel_rt;
      end
      // ALU output is valid one cycle after ISSUE; the flag is masked for non-compare ops.
      if (state == ST_WAIT) begin
        res_q <= alu_result_i;
        set_q <= alu_set_i & op_sets_flag(op_q[2:0]);
      end
    end
  end

  assign alu_opcode_o = op_q;
  assign alu_rs_o     = rs_q;
  assign alu_rt_o     = rt_q;
  assign rsp_result_o = res_q;
  assign rsp_set_o    = set_q;
  assign busy_o       = (state != ST_IDLE);
  assign grant_id_o   = grant_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: registered ALU stand-in, directed scenarios and random traffic
// checked each cycle against a transaction-level model of arbitration and response timing.
module tb_alu_share_ctrl;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*3-1:0] req_opcode;
  logic [N*8-1:0] req_rs, req_rt;
  logic [2:0]     op_a [N];
  logic [7:0]     rs_a [N];
  logic [7:0]     rt_a [N];
  logic [7:0]     rsp_result;
  logic           rsp_set;
  logic [2:0]     alu_opcode;
  logic [7:0]     alu_rs, alu_rt;
  logic [7:0]     alu_result = 8'h00;
  logic           alu_set = 1'b0;
  logic           busy;
  logic [0:0]     grant_id;

  int n_chk = 0;
  int n_err = 0;

  int         m_phase, m_owner, m_ptr;
  logic [2:0] m_op;
  logic [7:0] m_rs, m_rt, m_res;
  logic       m_set;
  bit         m_known = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_opcode[g*3 +: 3] = op_a[g];
    assign req_rs[g*8 +: 8]     = rs_a[g];
    assign req_rt[g*8 +: 8]     = rt_a[g];
  end

  alu_share_ctrl #(.NUM_REQ(N), .DATA_W(8), .OP_W(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_opcode_i (req_opcode),
    .req_rs_i     (req_rs),
    .req_rt_i     (req_rt),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result),
    .rsp_set_o    (rsp_set),
    .alu_opcode_o (alu_opcode),
    .alu_rs_o     (alu_rs),
    .alu_rt_o     (alu_rt),
    .alu_result_i (alu_result),
    .alu_set_i    (alu_set),
    .busy_o       (busy),
    .grant_id_o   (grant_id)
  );

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a + b;
      3'b010:  return a << b[2:0];
      3'b011:  return a >> b[2:0];
      3'b100:  return a - b;
      3'b101:  return {7'd0, $signed(a) < $signed(b)};
      3'b110:  return a[7] ? 8'(-a) : a;
      default: return {7'd0, a == b};
    endcase
  endfunction

  // ALU stand-in: one-cycle registered; set is the parity of the result, so it is
  // nonzero for many non-compare ops and the controller must mask it.
  always @(posedge clk) begin
    alu_result <= alu_fn(alu_opcode, alu_rs, alu_rt);
    alu_set    <= ^alu_fn(alu_opcode, alu_rs, alu_rt);
  end

  function automatic bit bit_at(input logic [31:0] v, input int k);
    return v[k[4:0]];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: compare DUT against the model for the current cycle, then advance the model.
  task automatic step();
    int   win;
    logic any;
    #1;
    win = 0;
    any = 1'b0;
    if (m_phase == 0) begin
      for (int i = 0; i < N; i++) begin
        if (!any && bit_at(32'(req_valid), (m_ptr + i) % N)) begin
          any = 1'b1;
          win = (m_ptr + i) % N;
        end
      end
    end
    if (m_known) begin
      check_eq("req_ready",  32'(req_ready),  any ? (32'd1 << win) : 32'd0);
      check_eq("rsp_valid",  32'(rsp_valid),  (m_phase == 3) ? (32'd1 << m_owner) : 32'd0);
      check_eq("rsp_result", 32'(rsp_result), 32'(m_res));
      check_eq("rsp_set",    32'(rsp_set),    32'(m_set));
      check_eq("busy",       32'(busy),       32'(m_phase != 0));
      check_eq("grant_id",   32'(grant_id),   32'(m_owner));
      check_eq("alu_in",     {13'd0, alu_opcode, alu_rs, alu_rt}, {13'd0, m_op, m_rs, m_rt});
    end
    if (rst) begin
      m_phase = 0; m_owner = 0; m_ptr = 0;
      m_op = '0; m_rs = '0; m_rt = '0; m_res = '0; m_set = 1'b0;
      m_known = 1'b1;
    end else begin
      case (m_phase)
        0: if (any) begin
          m_op = op_a[win]; m_rs = rs_a[win]; m_rt = rt_a[win];
          m_owner = win; m_phase = 1;
        end
        1: m_phase = 2;
        2: begin
          m_res   = alu_fn(m_op, m_rs, m_rt);
          m_set   = (m_op == 3'b101 || m_op == 3'b111) ? ^m_res : 1'b0;
          m_phase = 3;
        end
        default: if (bit_at(32'(rsp_ready), m_owner)) begin
          m_phase = 0;
`ifdef ALU_SHARE_FIXED_PRIO_EN
          m_ptr = 0;
`else
          m_ptr = (m_owner + 1) % N;
`endif
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rsp();
    int cnt = 0;
    while (rsp_valid == '0 && cnt < 20) begin
      step();
      cnt++;
    end
    if (rsp_valid == '0) check_eq("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int exp_g [3];
    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    for (int i = 0; i < N; i++) begin op_a[i] = '0; rs_a[i] = '0; rt_a[i] = '0; end
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    check_eq("rst_alu",       {13'd0, alu_opcode, alu_rs, alu_rt}, 32'd0);
    check_eq("rst_result",    32'(rsp_result), 32'd0);

    // Single ADD from requester 0: response three cycles after the handshake.
    op_a[0] = 3'b001; rs_a[0] = 8'h05; rt_a[0] = 8'h03;
    req_valid = 2'b01; rsp_ready = 2'b11;
    step();
    req_valid = 2'b00;
    step(); step();
    check_eq("single_valid",  32'(rsp_valid),  32'h1);
    check_eq("single_result", 32'(rsp_result), 32'h08);
    check_eq("single_set",    32'(rsp_set),    32'h0);
    step();
    check_eq("single_idle",   32'(busy),       32'h0);

    // Contention from reset: both requesters valid for three rounds.
    rst = 1'b1; step(); rst = 1'b0;
    op_a[0] = 3'b100; rs_a[0] = 8'h10; rt_a[0] = 8'h01;
    op_a[1] = 3'b001; rs_a[1] = 8'h7F; rt_a[1] = 8'h01;
    req_valid = 2'b11;
`ifdef ALU_SHARE_FIXED_PRIO_EN
    exp_g = '{0, 0, 0};
`else
    exp_g = '{0, 1, 0};
`endif
    for (int r = 0; r < 3; r++) begin
      wait_rsp();
      check_eq("cont_grant",  32'(grant_id),   32'(exp_g[r]));
      check_eq("cont_result", 32'(rsp_result), (exp_g[r] == 0) ? 32'h0F : 32'h80);
      step();
    end
    req_valid = 2'b00;
    while (busy) step();

    // Set flag passes only for compare opcodes.
    op_a[1] = 3'b111; rs_a[1] = 8'h22; rt_a[1] = 8'h22;
    req_valid = 2'b10;
    wait_rsp();
    check_eq("seq_set",    32'(rsp_set),    32'h1);
    check_eq("seq_result", 32'(rsp_result), 32'h1);
    step();
    op_a[1] = 3'b001; rs_a[1] = 8'h01; rt_a[1] = 8'h01;
    wait_rsp();
    check_eq("add_set",    32'(rsp_set),    32'h0);
    check_eq("add_result", 32'(rsp_result), 32'h02);
    req_valid = 2'b00;
    step();

    // Response stall with requester 0 pending; non-owner ready bit must be ignored.
    op_a[1] = 3'b000; rs_a[1] = 8'hF0; rt_a[1] = 8'h3C;
    op_a[0] = 3'b100; rs_a[0] = 8'h10; rt_a[0] = 8'h01;
    req_valid = 2'b10; rsp_ready = 2'b00;
    wait_rsp();
    req_valid = 2'b11; rsp_ready = 2'b01;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("stall_valid",  32'(rsp_valid),  32'h2);
      check_eq("stall_result", 32'(rsp_result), 32'h30);
      check_eq("stall_ready",  32'(req_ready),  32'h0);
    end
    rsp_ready = 2'b10;
    step();
    #1;
    check_eq("release_busy",  32'(busy),      32'h0);
    check_eq("release_ready", 32'(req_ready), 32'h1);
    rsp_ready = 2'b11;
    wait_rsp();
    check_eq("release_grant",  32'(grant_id),   32'h0);
    check_eq("release_result", 32'(rsp_result), 32'h0F);
    req_valid = 2'b00;
    step();

    // Reset while the ALU result is in flight: the operation vanishes.
    op_a[0] = 3'b001; rs_a[0] = 8'h40; rt_a[0] = 8'h02;
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    step();
    check_eq("pre_rst_busy", 32'(busy), 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    #1;
    check_eq("mid_rst_outs", {12'd0, rsp_valid, req_ready, busy, grant_id, rsp_set, 8'd0, rsp_result}, 32'd0);
    check_eq("mid_rst_alu",  {13'd0, alu_opcode, alu_rs, alu_rt}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("dropped_rsp", 32'(rsp_valid), 32'h0);
    end
    op_a[1] = 3'b001; rs_a[1] = 8'h03; rt_a[1] = 8'h04;
    req_valid = 2'b10;
    wait_rsp();
    check_eq("post_rst_grant",  32'(grant_id),   32'h1);
    check_eq("post_rst_result", 32'(rsp_result), 32'h07);
    req_valid = 2'b00;
    step();

    // Random traffic, occasional resets, random response back-pressure.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      for (int i = 0; i < N; i++) begin
        op_a[i] = 3'($urandom);
        rs_a[i] = 8'($urandom);
        rt_a[i] = 8'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
